// File: rtl/p405s_wd_rst_responder_pkg.sv
// Shared types for the watchdog reset responder: reset-type encodings (same
// encoding as the timer's wdRstType field), FSM states and priority helpers.
package p405s_wd_rst_responder_pkg;

  typedef enum logic [1:0] {
    RST_NONE = 2'b00,
    RST_CORE = 2'b01,
    RST_CHIP = 2'b10,
    RST_SYS  = 2'b11
  } rst_type_e;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StAssert  = 2'b01,
    StHold    = 2'b10,
    StRecover = 2'b11
  } wd_state_e;

  // Highest-priority pending request; the encoding order doubles as priority.
  function automatic rst_type_e prio_sel(input logic core, input logic chip, input logic sys);
    if (sys) begin
      return RST_SYS;
    end else if (chip) begin
      return RST_CHIP;
    end else if (core) begin
      return RST_CORE;
    end
    return RST_NONE;
  endfunction

  // One escalation step; a system reset is already the strongest type.
  function automatic rst_type_e next_type(input rst_type_e t);
    unique case (t)
      RST_CORE: return RST_CHIP;
      RST_CHIP: return RST_SYS;
      default:  return t;
    endcase
  endfunction

endpackage

// File: rtl/p405s_wd_rst_cnt.sv
// Loadable down-counter that saturates at zero, with a zero flag.
// Load has priority over decrement.
module p405s_wd_rst_cnt #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: load, else decrement without wrapping below zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/p405s_wd_rst_responder.sv
// Watchdog reset-request responder. Arbitrates level-held core/chip/system
// reset requests, drives a timed one-hot reset pulse plus reset back to the
// core, then enforces a quiet recovery window. Keeps a sticky last-cause field.
// Optional HOLD-timeout escalation is built when P405S_WDRST_ESCALATE_EN is
// defined; the default build waits in HOLD indefinitely.
module p405s_wd_rst_responder
  import p405s_wd_rst_responder_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned HOLD_TIMEOUT   = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic       CB,
  input  logic       syncRst,
  input  logic       wdCoreRstReq,
  input  logic       wdChipRstReq,
  input  logic       wdSysRstReq,
  input  logic       statusClr,
  output logic       coreRstOut,
  output logic       chipRstOut,
  output logic       sysRstOut,
  output logic       rstToCore,
  output logic [1:0] lastRstType,
  output logic       rstValid,
  output logic       rstBusy
);

  localparam logic [CNT_W-1:0] PulseLd   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RecoverLd = CNT_W'(RECOVER_CYCLES - 1);

  // Counter load values must fit the shared counter width.
  if (PULSE_CYCLES < 1 || PULSE_CYCLES >= (1 << CNT_W)) begin : g_bad_pulse
    $error("PULSE_CYCLES out of range");
  end
  if (RECOVER_CYCLES < 1 || RECOVER_CYCLES >= (1 << CNT_W)) begin : g_bad_recover
    $error("RECOVER_CYCLES out of range");
  end
  if (HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > (1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_TIMEOUT out of range");
  end

  wd_state_e        r_state;
  rst_type_e        r_type;

  rst_type_e        w_req_type;
  rst_type_e        w_type_new;
  logic             w_any_req;
  logic             w_active;
  logic             w_start;
  logic             w_upg;
  logic             w_esc;
  logic             w_release;
  logic             w_to_hold;
  logic             w_rec_done;
  logic             w_capture;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  assign w_req_type = prio_sel(wdCoreRstReq, wdChipRstReq, wdSysRstReq);
  assign w_any_req  = (w_req_type != RST_NONE);
  assign w_active   = (r_state == StAssert) || (r_state == StHold);
  assign w_start    = (r_state == StIdle) && w_any_req;
  assign w_upg      = w_active && (w_req_type > r_type);

  // The last ASSERT cycle already behaves like HOLD, so a request that is
  // gone by then releases straight away and the pulse is exactly PULSE_CYCLES.
  assign w_release  = (((r_state == StAssert) && w_cnt_zero) || (r_state == StHold)) &&
                      !w_any_req;
  assign w_to_hold  = (r_state == StAssert) && w_cnt_zero && w_any_req && !w_upg;
  assign w_rec_done = (r_state == StRecover) && w_cnt_zero;

`ifdef P405S_WDRST_ESCALATE_EN
  logic w_hold_zero;

  p405s_wd_rst_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .i_clk      (CB),
    .i_rst      (syncRst),
    .i_load     (w_to_hold),
    .i_load_val (CNT_W'(HOLD_TIMEOUT - 1)),
    .i_dec      ((r_state == StHold) && w_any_req),
    .o_zero     (w_hold_zero)
  );

  assign w_esc = (r_state == StHold) && w_any_req && !w_upg && w_hold_zero &&
                 (r_type != RST_SYS);
`else
  assign w_esc = 1'b0;
`endif

  assign w_capture  = w_start || w_upg || w_esc;
  assign w_type_new = w_esc ? next_type(r_type) : w_req_type;

  assign w_cnt_load = w_capture || w_release;
  assign w_cnt_val  = w_release ? RecoverLd : PulseLd;
  assign w_cnt_dec  = (r_state == StAssert) || (r_state == StRecover);

  p405s_wd_rst_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (CB),
    .i_rst      (syncRst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // FSM with registered reset outputs and the sticky cause field.
  always_ff @(posedge CB) begin
    if (syncRst) begin
      r_state     <= StIdle;
      r_type      <= RST_NONE;
      coreRstOut  <= 1'b0;
      chipRstOut  <= 1'b0;
      sysRstOut   <= 1'b0;
      rstToCore   <= 1'b0;
      rstBusy     <= 1'b0;
      lastRstType <= RST_NONE;
      rstValid    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_state    <= StAssert;
        r_type     <= w_type_new;
        coreRstOut <= (w_type_new == RST_CORE);
        chipRstOut <= (w_type_new == RST_CHIP);
        sysRstOut  <= (w_type_new == RST_SYS);
        rstToCore  <= 1'b1;
        rstBusy    <= 1'b1;
      end else if (w_release) begin
        r_state    <= StRecover;
        r_type     <= RST_NONE;
        coreRstOut <= 1'b0;
        chipRstOut <= 1'b0;
        sysRstOut  <= 1'b0;
        rstToCore  <= 1'b0;
      end else if (w_to_hold) begin
        r_state <= StHold;
      end else if (w_rec_done) begin
        r_state <= StIdle;
        rstBusy <= 1'b0;
      end

      // A capture in the same cycle as a clear keeps the new cause.
      if (w_capture) begin
        lastRstType <= w_type_new;
        rstValid    <= 1'b1;
      end else if (statusClr) begin
        lastRstType <= RST_NONE;
        rstValid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_p405s_wd_rst_responder.sv
// Bench for p405s_wd_rst_responder: directed scenarios with literal cycle
// expectations, then randomized requests checked every cycle against a
// timeline model (pulse age, quiet countdown, current cause).
module tb_p405s_wd_rst_responder;

  localparam int PULSE   = 8;
  localparam int RECOVER = 4;
  localparam int HOLD_TO = 64;

  logic       CB = 1'b0;
  logic       syncRst = 1'b1;
  logic       wdCoreRstReq = 1'b0;
  logic       wdChipRstReq = 1'b0;
  logic       wdSysRstReq = 1'b0;
  logic       statusClr = 1'b0;
  logic       coreRstOut;
  logic       chipRstOut;
  logic       sysRstOut;
  logic       rstToCore;
  logic [1:0] lastRstType;
  logic       rstValid;
  logic       rstBusy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  p405s_wd_rst_responder #(
    .PULSE_CYCLES   (PULSE),
    .RECOVER_CYCLES (RECOVER),
    .HOLD_TIMEOUT   (HOLD_TO),
    .CNT_W          (7)
  ) dut (
    .CB           (CB),
    .syncRst      (syncRst),
    .wdCoreRstReq (wdCoreRstReq),
    .wdChipRstReq (wdChipRstReq),
    .wdSysRstReq  (wdSysRstReq),
    .statusClr    (statusClr),
    .coreRstOut   (coreRstOut),
    .chipRstOut   (chipRstOut),
    .sysRstOut    (sysRstOut),
    .rstToCore    (rstToCore),
    .lastRstType  (lastRstType),
    .rstValid     (rstValid),
    .rstBusy      (rstBusy)
  );

  always #5 CB = ~CB;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Timeline model: m_age counts cycles since the pulse (re)started,
  // m_quiet counts remaining recovery cycles.
  bit m_active = 1'b0;
  int m_type   = 0;
  int m_age    = 0;
  int m_quiet  = 0;
  int m_last   = 0;
  bit m_valid  = 1'b0;

  always @(posedge CB) begin
    int req;
    bit cap;
    req = wdSysRstReq ? 3 : wdChipRstReq ? 2 : wdCoreRstReq ? 1 : 0;
    cap = 1'b0;
    if (syncRst) begin
      m_active = 1'b0; m_type = 0; m_age = 0; m_quiet = 0; m_last = 0; m_valid = 1'b0;
    end else begin
      if (m_quiet > 0) begin
        m_quiet--;
      end else if (!m_active) begin
        if (req != 0) begin
          m_active = 1'b1; m_type = req; m_age = 0; cap = 1'b1;
        end
      end else if (req > m_type) begin
        m_type = req; m_age = 0; cap = 1'b1;
      end else if (m_age >= PULSE - 1 && req == 0) begin
        m_active = 1'b0; m_type = 0; m_quiet = RECOVER;
`ifdef P405S_WDRST_ESCALATE_EN
      end else if (m_age == PULSE - 1 + HOLD_TO && m_type < 3) begin
        m_type++; m_age = 0; cap = 1'b1;
`endif
      end else begin
        m_age++;
      end
      if (cap) begin
        m_last = m_type; m_valid = 1'b1;
      end else if (statusClr) begin
        m_last = 0; m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CB) begin
    if (chk_en) begin
      chk("mdl_core", coreRstOut, m_active && m_type == 1);
      chk("mdl_chip", chipRstOut, m_active && m_type == 2);
      chk("mdl_sys", sysRstOut, m_active && m_type == 3);
      chk("mdl_rst_to_core", rstToCore, m_active);
      chk("mdl_busy", rstBusy, m_active || m_quiet > 0);
      chk("mdl_last", lastRstType, m_last);
      chk("mdl_valid", rstValid, m_valid);
    end
  end

  task automatic step();
    @(negedge CB);
  endtask

  initial begin
    step();
    step();
    syncRst = 1'b0;
    chk_en  = 1'b1;
    chk("rst_core", coreRstOut, 0);
    chk("rst_to_core", rstToCore, 0);
    chk("rst_busy", rstBusy, 0);
    chk("rst_last", lastRstType, 0);
    chk("rst_valid", rstValid, 0);
    repeat (4) step();

    // Core request held 20 sampled cycles.
    wdCoreRstReq = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("core_pulse", coreRstOut, k <= 20);
      chk("core_rst_to_core", rstToCore, k <= 20);
      chk("core_busy", rstBusy, k <= 24);
      if (k == 20) wdCoreRstReq = 1'b0;
    end
    chk("core_last", lastRstType, 1);
    chk("core_valid", rstValid, 1);
    repeat (3) step();

    // Simultaneous core and system request.
    wdCoreRstReq = 1'b1;
    wdSysRstReq  = 1'b1;
    step();
    chk("prio_sys", sysRstOut, 1);
    chk("prio_core", coreRstOut, 0);
    chk("prio_chip", chipRstOut, 0);
    chk("prio_last", lastRstType, 3);
    wdCoreRstReq = 1'b0;
    wdSysRstReq  = 1'b0;
    repeat (16) step();

    // Upgrade core -> chip three cycles into ASSERT.
    wdCoreRstReq = 1'b1;
    repeat (3) step();
    chk("upg_pre_core", coreRstOut, 1);
    wdChipRstReq = 1'b1;
    step();
    chk("upg_core_fall", coreRstOut, 0);
    chk("upg_chip_rise", chipRstOut, 1);
    chk("upg_last", lastRstType, 2);
    wdCoreRstReq = 1'b0;
    wdChipRstReq = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("upg_chip_len", chipRstOut, j <= 7);
    end
    repeat (8) step();
    statusClr = 1'b1;
    step();
    statusClr = 1'b0;
    chk("clr_valid", rstValid, 0);
    chk("clr_last", lastRstType, 0);

    // One-cycle request, re-raise during recovery, clear coincident with capture.
    wdCoreRstReq = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("short_core", coreRstOut, (k <= 8) || (k >= 14));
      chk("short_busy", rstBusy, (k <= 12) || (k >= 14));
      if (k >= 7 && k <= 13) chk("short_cleared", rstValid, 0);
      if (k == 14) begin
        chk("coinc_valid", rstValid, 1);
        chk("coinc_last", lastRstType, 1);
      end
      if (k == 1) wdCoreRstReq = 1'b0;
      if (k == 10) wdCoreRstReq = 1'b1;
      statusClr = (k == 5) || (k == 13);
    end
    wdCoreRstReq = 1'b0;
    statusClr = 1'b0;
    repeat (16) step();

    // Long-held core request: escalation only when the feature is built.
    wdCoreRstReq = 1'b1;
    for (int k = 1; k <= 73; k++) begin
      step();
      if (k == 72) chk("esc_pre_core", coreRstOut, 1);
      if (k == 73) begin
`ifdef P405S_WDRST_ESCALATE_EN
        chk("esc_chip", chipRstOut, 1);
        chk("esc_core", coreRstOut, 0);
        chk("esc_last", lastRstType, 2);
`else
        chk("noesc_core", coreRstOut, 1);
        chk("noesc_chip", chipRstOut, 0);
        chk("noesc_last", lastRstType, 1);
`endif
      end
    end
    wdCoreRstReq = 1'b0;
    repeat (16) step();

    // Synchronous reset while in HOLD.
    wdCoreRstReq = 1'b1;
    repeat (12) step();
    chk("midrst_pre", rstToCore, 1);
    syncRst = 1'b1;
    step();
    chk("midrst_core", coreRstOut, 0);
    chk("midrst_to_core", rstToCore, 0);
    chk("midrst_busy", rstBusy, 0);
    chk("midrst_last", lastRstType, 0);
    chk("midrst_valid", rstValid, 0);
    syncRst = 1'b0;
    wdCoreRstReq = 1'b0;
    step();
    chk("midrst_idle", rstBusy, 0);

    // Randomized requests: fast toggling first, then long holds.
    for (int c = 0; c < 4000; c++) begin
      int unsigned tog;
      tog = (c < 2000) ? 8 : 48;
      step();
      if ($urandom_range(tog - 1) == 0) wdCoreRstReq = ~wdCoreRstReq;
      if ($urandom_range(2 * tog - 1) == 0) wdChipRstReq = ~wdChipRstReq;
      if ($urandom_range(3 * tog - 1) == 0) wdSysRstReq = ~wdSysRstReq;
      statusClr = ($urandom_range(9) == 0);
      syncRst   = ($urandom_range(399) == 0);
    end
    step();
    syncRst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
